// File: rtl/radiant_evhdr_readout.sv
// Event header readout: streams a fixed ident dword followed by one dword popped
// from each of NUM_DYN first-word-fall-through header FIFOs, and flags FIFO misalignment.
module radiant_evhdr_readout #(
  parameter logic [31:0] IDENT   = 32'h52444530,
  parameter int          NUM_DYN = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [NUM_DYN-1:0]     fifo_empty_i,
  input  logic [32*NUM_DYN-1:0]  fifo_data_i,
  output logic [NUM_DYN-1:0]     fifo_rden_o,
  output logic [31:0]            hdr_tdata_o,
  output logic                   hdr_tvalid_o,
  input  logic                   hdr_tready_i,
  output logic                   hdr_tlast_o,
  output logic                   event_done_o,
  output logic [31:0]            events_read_o,
  output logic                   desync_o,
  input  logic                   desync_clr_i
);

  localparam int               IDX_W    = $clog2(NUM_DYN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DYN);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [1:0]       mix_cnt;
  logic             none_empty;
  logic             all_empty;
  logic             mixed;
  logic             beat;
  logic [31:0]      dyn_word;

  assign none_empty = (fifo_empty_i == '0);
  assign all_empty  = &fifo_empty_i;
  assign mixed      = !none_empty && !all_empty;

  // Outputs are gated by rst_i so a reset landing mid-header pops nothing.
  assign hdr_tvalid_o = (state == SEND) && !rst_i;
  assign beat         = hdr_tvalid_o && hdr_tready_i;
  assign hdr_tlast_o  = hdr_tvalid_o && (idx == LAST_IDX);
  assign event_done_o = (state == DONE) && !rst_i;

  always_comb begin
    dyn_word    = '0;
    fifo_rden_o = '0;
    for (int k = 0; k < NUM_DYN; k++) begin
      if (idx == IDX_W'(k + 1)) begin
        dyn_word       = fifo_data_i[32*k +: 32];
        fifo_rden_o[k] = beat;
      end
    end
  end

  assign hdr_tdata_o = (idx == '0) ? IDENT : dyn_word;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      idx           <= '0;
      mix_cnt       <= '0;
      events_read_o <= '0;
      desync_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i && none_empty) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (beat) begin
            if (idx == LAST_IDX) state <= DONE;
            else                 idx   <= idx + 1'b1;
          end
        end
        DONE: begin
          events_read_o <= events_read_o + 32'd1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Misalignment: FIFOs should empty and fill together while idle.
      if (desync_clr_i) begin
        desync_o <= 1'b0;
        mix_cnt  <= '0;
      end else if ((state == IDLE) && mixed) begin
        if (mix_cnt == 2'd3) desync_o <= 1'b1;
        else                 mix_cnt  <= mix_cnt + 2'd1;
      end else begin
        mix_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_radiant_evhdr_readout.sv
// Scoreboard bench for radiant_evhdr_readout: FIFO model plus expected-beat queue.
module tb_radiant_evhdr_readout;

  localparam int          N       = 5;
  localparam logic [31:0] IDENT_C = 32'h52444530;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            enable_i = 1'b0;
  logic [N-1:0]    fifo_empty_i;
  logic [32*N-1:0] fifo_data_i;
  logic [N-1:0]    fifo_rden_o;
  logic [31:0]     hdr_tdata_o;
  logic            hdr_tvalid_o;
  logic            hdr_tready_i = 1'b0;
  logic            hdr_tlast_o;
  logic            event_done_o;
  logic [31:0]     events_read_o;
  logic            desync_o;
  logic            desync_clr_i = 1'b0;

  radiant_evhdr_readout dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_rden_o(fifo_rden_o),
    .hdr_tdata_o(hdr_tdata_o), .hdr_tvalid_o(hdr_tvalid_o), .hdr_tready_i(hdr_tready_i),
    .hdr_tlast_o(hdr_tlast_o), .event_done_o(event_done_o), .events_read_o(events_read_o),
    .desync_o(desync_o), .desync_clr_i(desync_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  data;
    logic         last;
    logic [N-1:0] rden;
  } beat_t;

  logic [31:0] fq [N][$];
  beat_t       expq [$];
  logic [31:0] setw [N];
  logic        force_en = 1'b0;
  logic [N-1:0] force_val = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_cnt = 0;
  logic        done_pend = 0;
  logic        cnt_chk = 0;

  logic         valid_s, beat_s, last_s;
  logic [N-1:0] rden_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      fifo_empty_i[k]         = (fq[k].size() == 0);
      fifo_data_i[32*k +: 32] = (fq[k].size() > 0) ? fq[k][0] : (32'hDEAD0000 | k);
    end
    if (force_en) fifo_empty_i = force_val;
  endtask

  // One header's worth: one word into every FIFO and the six beats it must produce.
  task automatic push_set();
    beat_t e;
    e.data = IDENT_C; e.last = 1'b0; e.rden = '0;
    expq.push_back(e);
    for (int k = 0; k < N; k++) begin
      fq[k].push_back(setw[k]);
      e.data = setw[k]; e.last = (k == N - 1); e.rden = N'(1) << k;
      expq.push_back(e);
    end
    refresh();
  endtask

  task automatic push_random();
    for (int k = 0; k < N; k++) setw[k] = $urandom;
    push_set();
  endtask

  task automatic flush_fifos();
    for (int k = 0; k < N; k++) fq[k].delete();
    refresh();
  endtask

  task automatic tick();
    @(negedge clk);
    valid_s = hdr_tvalid_o;
    beat_s  = hdr_tvalid_o && hdr_tready_i;
    last_s  = hdr_tlast_o;
    rden_s  = fifo_rden_o;
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (rden_s[k] && fq[k].size() > 0) void'(fq[k].pop_front());
    #1;
    refresh();
  endtask

  // Monitor: compares every presented beat against the scoreboard queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_i) begin
      chk("rst_tvalid", {31'd0, hdr_tvalid_o}, 32'd0);
      chk("rst_tlast", {31'd0, hdr_tlast_o}, 32'd0);
      chk("rst_rden", {27'd0, fifo_rden_o}, 32'd0);
      chk("rst_event_done", {31'd0, event_done_o}, 32'd0);
      done_pend = 1'b0;
      cnt_chk   = 1'b0;
      model_cnt = 32'd0;
    end else begin
      if (cnt_chk) begin
        chk("events_read", events_read_o, model_cnt);
        cnt_chk = 1'b0;
      end
      if (done_pend || event_done_o) begin
        chk("event_done", {31'd0, event_done_o}, {31'd0, done_pend});
        if (done_pend) begin
          model_cnt = model_cnt + 32'd1;
          cnt_chk   = 1'b1;
        end
        done_pend = 1'b0;
      end
      if (hdr_tvalid_o && hdr_tready_i) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", hdr_tdata_o, 32'hFFFFFFFF);
        end else begin
          e = expq.pop_front();
          chk("beat_data", hdr_tdata_o, e.data);
          chk("beat_last", {31'd0, hdr_tlast_o}, {31'd0, e.last});
          chk("beat_rden", {27'd0, fifo_rden_o}, {27'd0, e.rden});
          if (e.last) done_pend = 1'b1;
        end
      end else begin
        if (hdr_tvalid_o && expq.size() > 0) begin
          chk("stall_data", hdr_tdata_o, expq[0].data);
          chk("stall_last", {31'd0, hdr_tlast_o}, {31'd0, expq[0].last});
        end
        if (fifo_rden_o != '0) chk("rden_no_beat", {27'd0, fifo_rden_o}, 32'd0);
      end
    end
  end

  initial begin
    int nb, cnt, rd, first_b, last_b, vcount;
    logic started, fin;
    refresh();

    // Reset state
    tick(); tick();
    chk("rst_events_read", events_read_o, 32'd0);
    chk("rst_desync", {31'd0, desync_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    chk("idle_tvalid", {31'd0, hdr_tvalid_o}, 32'd0);

    // Scenario 1: back-to-back header with fixed data
    for (int k = 0; k < N; k++) setw[k] = 32'h11 * (k + 1);
    enable_i = 1'b1; hdr_tready_i = 1'b1;
    push_set();
    nb = 0; first_b = -1; last_b = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (beat_s) begin
        if (nb == 0) first_b = i;
        nb++;
        if (last_s) last_b = i;
      end
    end
    chk("s1_beats", nb, 6);
    chk("s1_consecutive", last_b - first_b, 5);
    chk("s1_events_read", events_read_o, 32'd1);

    // Scenario 2: ready toggling every cycle
    push_random();
    started = 0; fin = 0; cnt = 0; rd = 0;
    hdr_tready_i = 1'b1;
    for (int i = 0; i < 60 && !fin; i++) begin
      if (started) hdr_tready_i = ~hdr_tready_i;
      tick();
      if (valid_s) started = 1;
      if (started) cnt++;
      rd += $countones(rden_s);
      if (beat_s && last_s) fin = 1;
    end
    chk("s2_finished", {31'd0, fin}, 32'd1);
    chk("s2_cycles", cnt, 11);
    chk("s2_rden_pulses", rd, 5);
    hdr_tready_i = 1'b1;
    tick(); tick(); tick();

    // Scenario 3: mixed-empty desync detection
    enable_i = 1'b0;
    force_en = 1'b1; force_val = 5'b00100; refresh();
    tick(); tick(); tick();
    chk("s3_after3", {31'd0, desync_o}, 32'd0);
    force_val = 5'b00000; refresh();
    tick();
    chk("s3_cleared_run", {31'd0, desync_o}, 32'd0);
    force_val = 5'b00100; refresh();
    tick(); tick(); tick();
    chk("s3_mixed3_again", {31'd0, desync_o}, 32'd0);
    tick();
    chk("s3_mixed4", {31'd0, desync_o}, 32'd1);
    force_en = 1'b0; refresh();
    tick(); tick(); tick();
    chk("s3_sticky", {31'd0, desync_o}, 32'd1);
    desync_clr_i = 1'b1;
    tick();
    desync_clr_i = 1'b0;
    chk("s3_clr", {31'd0, desync_o}, 32'd0);

    // Scenario 4: reset mid-header
    enable_i = 1'b1; hdr_tready_i = 1'b1;
    push_random();
    nb = 0;
    for (int i = 0; i < 20 && nb < 3; i++) begin
      tick();
      if (beat_s) nb++;
    end
    chk("s4_reached_beat3", nb, 3);
    rst_i = 1'b1;
    expq.delete();
    tick();
    chk("s4_rst_rden", {27'd0, rden_s}, 32'd0);
    rst_i = 1'b0;
    flush_fifos();
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_s) vcount++;
    end
    chk("s4_no_tvalid", vcount, 0);
    chk("s4_events_read", events_read_o, 32'd0);

    // Scenario 5: event counter wrap
    force dut.events_read_o = 32'hFFFFFFFF;
    model_cnt = 32'hFFFFFFFF;
    #2;
    release dut.events_read_o;
    push_random();
    for (int i = 0; i < 15; i++) tick();
    chk("s5_wrap", events_read_o, 32'd0);

    // Scenario 6: enable dropped mid-header
    push_random(); push_random();
    nb = 0;
    for (int i = 0; i < 20 && nb < 2; i++) begin
      tick();
      if (beat_s) nb++;
    end
    enable_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (beat_s) nb++;
    end
    chk("s6_one_header", nb, 6);
    chk("s6_pending_beats", expq.size(), 6);
    enable_i = 1'b1;
    for (int i = 0; i < 15; i++) tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 6) == 0 && fq[0].size() < 4) push_random();
      hdr_tready_i = ($urandom % 4) != 0;
      enable_i     = ($urandom % 8) != 0;
      tick();
    end
    enable_i = 1'b1; hdr_tready_i = 1'b1;
    for (int i = 0; i < 300 && expq.size() > 0; i++) tick();
    chk("drain_left", expq.size(), 0);
    tick(); tick(); tick();
    chk("final_desync", {31'd0, desync_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/radiant_evhdr_readout.md
RADIANT_EVHDR_READOUT -- requirements
Module: radiant_evhdr_readout

Interface
REQ-001 The block SHALL have parameter IDENT, default 32'h52444530 ("RDE0"), the header dword 0 value.
REQ-002 The block SHALL have parameter NUM_DYN, default 5, the number of header FIFOs (dynamic dwords).
REQ-003 The block SHALL use one clock, clk_i, and a synchronous active-high reset, rst_i; all logic SHALL be in the clk_i domain.
REQ-004 The block SHALL have port clk_i, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port enable_i, input, 1 bit: permits starting a new header.
REQ-007 The block SHALL have port fifo_empty_i, input, NUM_DYN bits: per-FIFO empty flag (first-word-fall-through FIFOs).
REQ-008 The block SHALL have port fifo_data_i, input, 32*NUM_DYN bits: FIFO k head dword at bits [32k+31:32k].
REQ-009 The block SHALL have port fifo_rden_o, output, NUM_DYN bits: one-hot pop strobes.
REQ-010 The block SHALL have port hdr_tdata_o, output, 32 bits: header stream data.
REQ-011 The block SHALL have ports hdr_tvalid_o (output, 1 bit) and hdr_tready_i (input, 1 bit): stream handshake.
REQ-012 The block SHALL have port hdr_tlast_o, output, 1 bit: marks the final header dword.
REQ-013 The block SHALL have port event_done_o, output, 1 bit: one-cycle pulse per completed header.
REQ-014 The block SHALL have port events_read_o, output, 32 bits: count of completed headers.
REQ-015 The block SHALL have port desync_o, output, 1 bit: sticky FIFO-misalignment error.
REQ-016 The block SHALL have port desync_clr_i, input, 1 bit: clears desync_o.

Function
REQ-017 The state machine SHALL have exactly three states: IDLE, SEND and DONE.
REQ-018 IDLE -> SEND SHALL occur when enable_i=1 and fifo_empty_i is all-zero, and SHALL load idx=0.
REQ-019 In SEND, hdr_tvalid_o SHALL be 1, and hdr_tdata_o SHALL be IDENT when idx=0, else fifo_data_i slice idx-1.
REQ-020 In SEND, a beat SHALL complete on a cycle with hdr_tvalid_o=1 and hdr_tready_i=1; idx SHALL then increment.
REQ-021 fifo_rden_o[idx-1] SHALL be 1 (combinationally) only on a completed beat with idx>=1; fifo_rden_o SHALL be 0 at all other times.
REQ-022 hdr_tlast_o SHALL be 1 only while idx=NUM_DYN in SEND; a completed beat at that idx SHALL transition to DONE.
REQ-023 While hdr_tready_i=0, hdr_tdata_o, hdr_tlast_o and idx SHALL be held stable.
REQ-024 DONE SHALL last exactly one cycle: event_done_o=1, events_read_o increments (32-bit wrap, 0xFFFFFFFF->0), then -> IDLE.
REQ-025 The minimum time from entering SEND to the next SEND SHALL be NUM_DYN+3 cycles: NUM_DYN+1 beats, 1 DONE cycle, 1 IDLE cycle.
REQ-026 Deasserting enable_i mid-header SHALL NOT abort the header; it SHALL only block the next IDLE->SEND transition.
REQ-027 In SEND, FIFO emptiness SHALL be ignored.
REQ-028 In IDLE, if fifo_empty_i is neither all-0 nor all-1 for 4 consecutive cycles, desync_o SHALL be set and held.
REQ-029 The mixed-empty cycle counter SHALL clear on any all-0 or all-1 cycle.
REQ-030 desync_clr_i SHALL clear desync_o and the mixed-empty cycle counter.
REQ-031 If desync_o is set and desync_clr_i is asserted in the same cycle, the clear SHALL win.
REQ-032 The IDLE->SEND transition SHALL be unaffected by desync_o.

Reset
REQ-033 On rst_i=1 the block SHALL enter IDLE with idx=0 and the mixed-empty counter at 0.
REQ-034 On rst_i=1 the outputs SHALL be: hdr_tvalid_o=0, hdr_tlast_o=0, fifo_rden_o=0, event_done_o=0, events_read_o=0, desync_o=0.
REQ-035 Reset asserted mid-header SHALL abandon the header with no further pops; no event_done_o pulse SHALL be generated.

Verification
REQ-036 Scenario 1: all FIFOs non-empty with data 0x11..0x55, enable_i=1, hdr_tready_i=1 -> 6 consecutive beats 0x52444530,0x11,0x22,0x33,0x44,0x55; tlast on beat 6; rden bits 0..4 pulse on beats 2..6; event_done_o 1 cycle later; events_read_o=1.
REQ-037 Scenario 2: hdr_tready_i toggled 0/1 each cycle through a header -> data and tlast held during stalls; exactly 5 rden pulses; 11 cycles from first tvalid to last beat.
REQ-038 Scenario 3: fifo_empty_i=5'b00100 held 3 cycles, then 5'b00000 -> desync_o stays 0; held 4 cycles -> desync_o=1 and stays 1 until desync_clr_i.
REQ-039 Scenario 4: rst_i pulsed after beat 3 -> tvalid=0 the next cycle, no rden, no event_done_o, events_read_o=0.
REQ-040 Scenario 5: events_read_o preloaded via 0xFFFFFFFF completions (or forced) plus one header -> events_read_o=0.
REQ-041 Scenario 6: enable_i dropped after beat 2 -> header completes with 6 beats; no new SEND while enable_i=0 with FIFOs non-empty.
